// File: rtl/fir_filter_mac.sv
// Direct-form FIR filter with a runtime-loadable coefficient bank and one time-multiplexed MAC.
// Latency: sample accepted at edge 0 gives out_valid after edge TAPS+1; one sample per TAPS+2 cycles.
// Backpressure: in_ready is low during MAC/DONE; samples offered while busy are dropped, not queued.
//
// Ports:
//   clk, rst_n              clock (rising edge) and asynchronous active-low reset
//   input_sig/in_valid      signed sample and strobe; accepted when in_valid && in_ready
//   in_ready                high while idle
//   coef_we/addr/data       coefficient write port, honoured only while idle and addr < TAPS
//                           (addr 0 multiplies the newest sample)
//   clr                     synchronous flush of delay line and accumulator, highest priority
//   output_sig              rounded, saturated result, held between updates
//   out_valid/sat           one-cycle pulses; sat marks a clipped result
module fir_filter_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 16,
    parameter int OUT_SHIFT = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   input_sig,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       clr,
    output logic signed [DATA_W-1:0]   output_sig,
    output logic                       out_valid,
    output logic                       sat
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    // One extra bit so adding the rounding constant can never wrap.
    localparam int RW    = ACC_W + 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_EXT = (AW + 1)'(TAPS);

    localparam logic signed [RW-1:0] RND_C =
        (OUT_SHIFT > 0) ? (RW'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam logic signed [RW-1:0] MAX_V = RW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] MIN_V = -MAX_V - RW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic signed [DATA_W-1:0]    x_q    [TAPS];
    logic signed [COEF_W-1:0]    coef_q [TAPS];
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [AW-1:0]               k_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [DATA_W-1:0]    out_q;
    logic                        out_valid_q;
    logic                        sat_q;

    logic signed [PW-1:0]        prod;
    logic signed [RW-1:0]        rnd_sum;
    logic signed [RW-1:0]        shifted;
    logic signed [DATA_W-1:0]    res_d;
    logic                        sat_d;
    logic [AW-1:0]               wr_ptr_d;
    logic [AW-1:0]               rd_ptr_d;
    logic                        coef_ok;

    always_comb begin
        prod     = coef_q[k_q] * x_q[rd_ptr_q];
        rnd_sum  = RW'(acc_q) + RND_C;
        shifted  = rnd_sum >>> OUT_SHIFT;
        res_d    = shifted[DATA_W-1:0];
        sat_d    = 1'b0;
        if (shifted > MAX_V) begin
            res_d = MAX_V[DATA_W-1:0];
            sat_d = 1'b1;
        end else if (shifted < MIN_V) begin
            res_d = MIN_V[DATA_W-1:0];
            sat_d = 1'b1;
        end
        // Explicit wraps so non-power-of-two TAPS stays inside the buffer.
        wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        // Walking backwards from the newest sample gives x[n-k] for tap k.
        rd_ptr_d = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
        coef_ok  = coef_we && ({1'b0, coef_addr} < TAPS_EXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            if (clr) begin
                // Coefficients and output_sig deliberately survive a flush.
                state_q  <= IDLE;
                wr_ptr_q <= '0;
                acc_q    <= '0;
                for (int i = 0; i < TAPS; i++) begin
                    x_q[i] <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        // The coefficient bank is read from the next edge on, so a
                        // write in the accepting cycle already applies to this sample.
                        if (coef_ok) begin
                            coef_q[coef_addr] <= coef_data;
                        end
                        if (in_valid) begin
                            x_q[wr_ptr_q] <= input_sig;
                            rd_ptr_q      <= wr_ptr_q;
                            wr_ptr_q      <= wr_ptr_d;
                            acc_q         <= '0;
                            k_q           <= '0;
                            state_q       <= MAC;
                        end
                    end
                    MAC: begin
                        acc_q    <= acc_q + ACC_W'(prod);
                        rd_ptr_q <= rd_ptr_d;
                        k_q      <= k_q + 1'b1;
                        if (k_q == LAST_IDX) begin
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        sat_q       <= sat_d;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign output_sig = out_q;
    assign out_valid  = out_valid_q;
    assign sat        = sat_q;

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
Parametrised successor to the fixed 8-bit FIR filters. It is a direct-form FIR with a runtime-loadable coefficient bank. A single time-multiplexed multiplier-accumulator computes the taps, one tap per clock. Output uses round-half-up, arithmetic shift and saturation, with a valid/ready handshake on the input and a valid strobe on the output. It sits between the sample source and downstream logic, exploiting the idle clocks between input samples.

Parameters:
DATA_W, 8, signed input/output sample width
COEF_W, 8, signed coefficient width
TAPS, 16, number of taps (>=2); also MAC cycles per sample
OUT_SHIFT, 7, arithmetic right shift applied to accumulator (coefficient fraction bits; 0 allowed)
(localparam ACC_W = DATA_W + COEF_W + clog2(TAPS); accumulator never overflows)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
input_sig  in  DATA_W  signed input sample
in_valid  in  1  sample strobe; accepted when in_valid && in_ready
in_ready  out  1  high when idle and able to accept a sample
coef_we  in  1  coefficient write enable
coef_addr  in  clog2(TAPS)  coefficient index (0 = newest sample tap)
coef_data  in  COEF_W  signed coefficient value
clr  in  1  synchronous flush of delay line and accumulator
output_sig  out  DATA_W  signed filtered sample, held between updates
out_valid  out  1  one-cycle pulse when output_sig updates
sat  out  1  one-cycle pulse with out_valid when the result was clipped

Behaviour:
- Reset (async, rst_n=0): delay line, coefficients, accumulator, output_sig = 0; out_valid = 0; sat = 0; in_ready = 1; FSM = IDLE.
- Delay line: circular buffer of TAPS samples with a write pointer; the pointer wraps TAPS-1 -> 0.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: write input_sig at the pointer, clear acc, k = 0, go to MAC.
- MAC (exactly TAPS cycles):
  - acc += coef[k] * x[n-k], full-precision signed product, sign-extended to ACC_W.
  - k increments; after k = TAPS-1 go to DONE.
- DONE (1 cycle):
  - r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the result into output_sig; pulse out_valid; sat = 1 iff clipped.
  - Return to IDLE.
- Latency: sample accepted at edge 0 -> out_valid high after edge TAPS+1. Throughput: one sample per TAPS+2 cycles. Back-to-back in_valid is accepted in the cycle after DONE.
- in_ready = 0 in MAC and DONE. in_valid asserted while in_ready = 0 is ignored (sample dropped, no state change).
- Coefficient writes:
  - Take effect only in IDLE and when coef_addr < TAPS.
  - Writes in MAC/DONE or to out-of-range addresses are ignored.
  - coef_we with in_valid in the same IDLE cycle: the write lands first and applies to that sample.
- clr:
  - In any state: zero the delay line and acc, pointer = 0, FSM = IDLE, no out_valid.
  - output_sig keeps its last value; coefficients are kept.
  - clr has priority over in_valid and coef_we in the same cycle.
- Reset mid-MAC: the computation is aborted, out_valid is never asserted for that sample, and all state is as in reset.

Test Plan:
1. Impulse response. DATA_W=8, TAPS=4, OUT_SHIFT=0, coefs {1,2,3,4}. Input 10, then 0,0,0,0 -> outputs 10,20,30,40,0; each out_valid comes 5 cycles after its accept; sat=0.
2. Saturation. coefs all 100, OUT_SHIFT=0. Input 100 -> output 127, sat=1. Then input -128 with coefs all 127 -> output -128, sat=1.
3. Rounding. OUT_SHIFT=1, coef[0]=1, others 0. Input 3 -> 2. Input -3 -> -1. Input 4 -> 2.
4. Handshake. Assert in_valid every cycle with samples 1,2,3,... -> only every (TAPS+2)th sample is accepted; in_ready=0 during MAC/DONE; dropped samples never affect the output.
5. Coefficient guard. coef_we during MAC with addr 0, data 50 -> coef unchanged, current and next outputs match the old coefs. Write to addr >= TAPS (TAPS=3) -> no effect.
6. Clear/reset. Pulse clr at MAC cycle 2 -> no out_valid, in_ready=1 next cycle, next impulse gives a clean response. Repeat with rst_n low mid-MAC -> output_sig=0, coefs=0, next sample output 0.
